// File: rtl/apb_master.sv
// apb_master: request-to-APB requester FSM; `define APB_MASTER_TIMEOUT_EN adds an ACCESS-phase timeout abort
module apb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W/8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_strb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic [STRB_W-1:0] PSTRB,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t r_state, w_next;
  logic w_accept, w_misalign, w_done, w_abort;
  logic r_err, r_timeout;
  logic [DATA_W-1:0] r_rdata;
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_timeout_cyc_out_of_range
  end
  assign w_accept   = req_valid && r_state == IDLE;
  assign w_misalign = req_addr[1:0] != 2'b00;
  assign w_done     = r_state == ACCESS && PREADY;
`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (r_state == SETUP) r_cnt <= '0;
    else if (r_state == ACCESS && !PREADY) r_cnt <= r_cnt + 16'd1;
  assign w_abort = r_state == ACCESS && !PREADY && r_cnt == 16'(TIMEOUT_CYC);
`else
  assign w_abort = 1'b0;
`endif
  always_comb begin
    w_next = r_state == IDLE   ? (w_accept ? (w_misalign ? RESP : SETUP) : IDLE)
           : r_state == SETUP  ? ACCESS
           : r_state == ACCESS ? ((w_done || w_abort) ? RESP : ACCESS)
           : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (w_accept && !w_misalign) begin
      PADDR  <= req_addr;
      PWRITE <= req_write;
      PWDATA <= req_wdata;
      PSTRB  <= req_write ? req_strb : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_accept && w_misalign) begin
      r_rdata   <= '0;
      r_err     <= 1'b1;
      r_timeout <= 1'b0;
    end else if (w_done) begin
      r_rdata   <= PWRITE ? '0 : PRDATA;
      r_err     <= PSLVERR;
      r_timeout <= 1'b0;
    end else if (w_abort) begin
      r_rdata   <= '0;
      r_err     <= 1'b1;
      r_timeout <= 1'b1;
    end
  end
  assign req_ready   = r_state == IDLE;
  assign PSEL        = r_state == SETUP || r_state == ACCESS;
  assign PENABLE     = r_state == ACCESS;
  assign rsp_valid   = r_state == RESP;
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign rsp_timeout = r_timeout;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed and random transfers against a latency/response model of the APB requester
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_strb = '0;
  logic rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic PWRITE, PSEL, PENABLE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA = '0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] prev_rdata = '0;
  logic prev_err = 1'b0, prev_to = 1'b0;
  logic [AW-1:0] last_paddr = '0;
  always #5 clk = ~clk;
  apb_master #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                      input logic [SW-1:0] st, input int waits, input logic [DW-1:0] rd, input logic se);
    bit mis, tmo;
    int lat;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    mis = a[1:0] != 2'b00;
    tmo = !mis && TO_EN && waits > TO;
    lat = mis ? 1 : 3 + (tmo ? TO : waits);
    exp_rd = (mis || tmo || w) ? '0 : rd;
    exp_err = mis || tmo || se;
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd; req_strb = st; PREADY = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    chk("psel_idle", 64'(PSEL), 64'd0);
    chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    chk("rsp_rdata_hold", 64'(rsp_rdata), 64'(prev_rdata));
    chk("rsp_err_hold", 64'(rsp_err), 64'(prev_err));
    chk("rsp_timeout_hold", 64'(rsp_timeout), 64'(prev_to));
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom; req_strb = 4'($urandom);
    for (int c = 1; c <= lat; c++) begin
      PREADY = (c == 2 + waits);
      PRDATA = PREADY ? rd : $urandom;
      PSLVERR = PREADY ? se : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("psel", 64'(!mis && c < lat), 64'(PSEL) ^ 64'd0);
      chk("penable", 64'(PENABLE), 64'(!mis && c >= 2 && c < lat));
      chk("rsp_valid", 64'(rsp_valid), 64'(c == lat));
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      if (!mis && c < lat) begin
        chk("paddr", 64'(PADDR), 64'(a));
        chk("pwrite", 64'(PWRITE), 64'(w));
        chk("pwdata", 64'(PWDATA), 64'(wd));
        chk("pstrb", 64'(PSTRB), 64'(w ? st : 4'h0));
      end
      if (c == lat) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(tmo));
      end
      @(posedge clk); #1;
    end
    PREADY = 1'b0;
    prev_rdata = exp_rd; prev_err = exp_err; prev_to = tmo;
    if (!mis) last_paddr = a;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_pstrb", 64'(PSTRB), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    xfer(32'h1000_0004, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h5555AAAA, 1'b0);
    xfer(32'h1000_0008, 1'b0, 32'h0BAD0BAD, 4'hF, 3, 32'h12345678, 1'b0);
    xfer(32'h1000_000C, 1'b0, 32'h0, 4'h3, 1, 32'hCAFEF00D, 1'b1);
    xfer(32'h1000_0010, 1'b1, 32'hA5A5A5A5, 4'h6, 2, 32'h0, 1'b0);
    xfer(32'h1000_0002, 1'b1, 32'h11111111, 4'hF, 0, 32'h0, 1'b0);
    xfer(32'h2000_0000, 1'b0, 32'h0, 4'h0, TO, 32'h87654321, 1'b0);
    xfer(32'h2000_0004, 1'b0, 32'h0, 4'h0, 20, 32'h0F0F0F0F, 1'b0);
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      a = $urandom & ~32'h3;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom_range(0, 6),
           $urandom, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_psel", 64'(PSEL), 64'd0);
        chk("gap_paddr_hold", 64'(PADDR), 64'(last_paddr));
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b1; req_addr = 32'h3000_0000; req_write = 1'b0; PREADY = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_psel", 64'(PSEL), 64'd1);
    chk("pre_rst_penable", 64'(PENABLE), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_psel", 64'(PSEL), 64'd0);
    chk("async_rst_penable", 64'(PENABLE), 64'd0);
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_paddr", 64'(PADDR), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    prev_rdata = '0; prev_err = 1'b0; prev_to = 1'b0;
    xfer(32'h1000_0020, 1'b0, 32'h0, 4'hF, 1, 32'h600DF00D, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the request and APB address buses.
REQ-002 Parameter DATA_W, default 32, data width of the write and read data buses.
REQ-003 Parameter STRB_W, default DATA_W/8, width of the byte-strobe buses.
REQ-004 Parameter TIMEOUT_CYC, default 255, maximum number of ACCESS cycles with PREADY low before abort; legal range is 1 to 65535.
REQ-005 Port clk, input, 1 bit, the single clock; every flop of the block is on its rising edge.
REQ-006 Port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-007 Port req_valid, input, 1 bit, a transfer request is present.
REQ-008 Port req_ready, output, 1 bit, the request is accepted in any cycle where req_valid and req_ready are both 1.
REQ-009 Ports req_addr (input, ADDR_W), req_write (input, 1), req_wdata (input, DATA_W) and req_strb (input, STRB_W) carry the request fields.
REQ-010 Port rsp_valid, output, 1 bit, a one-cycle pulse that completes a transfer.
REQ-011 Ports rsp_rdata (output, DATA_W), rsp_err (output, 1) and rsp_timeout (output, 1) carry the response fields.
REQ-012 Ports PADDR (output, ADDR_W), PWRITE (output, 1), PWDATA (output, DATA_W), PSTRB (output, STRB_W), PSEL (output, 1) and PENABLE (output, 1) form the APB requester side.
REQ-013 Ports PRDATA (input, DATA_W), PREADY (input, 1) and PSLVERR (input, 1) form the APB completer side.

Function
REQ-014 The state machine SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-015 IDLE: req_ready is 1 and PSEL is 0; on handshake with aligned req_addr[1:0]==0, latch all request fields and move to SETUP.
REQ-016 Misaligned request (req_addr[1:0]!=0): accept, issue no bus cycle, go to RESP with rsp_err=1, rsp_rdata=0.
REQ-017 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from the latched request; the next state is always ACCESS.
REQ-018 ACCESS: PSEL=1, PENABLE=1; all APB outputs stay stable until exit.
REQ-019 ACCESS with PREADY=1: capture PSLVERR into rsp_err and, for reads, capture PRDATA into rsp_rdata; move to RESP.
REQ-020 Writes return rsp_rdata=0; reads drive PSTRB=0 regardless of req_strb.
REQ-021 RESP: rsp_valid=1 for exactly one cycle, PSEL=0, req_ready=0; the next state is always IDLE.
REQ-022 Latency: request accepted in cycle N, with zero wait states -> SETUP N+1, ACCESS N+2, rsp_valid N+3; each PREADY-low cycle adds 1.
REQ-023 The minimum request-to-request spacing is 4 cycles; req_ready is 0 outside IDLE.
REQ-024 Response fields SHALL hold their values until the next rsp_valid; PADDR/PWDATA hold their last values in IDLE.
REQ-025 PENABLE is never 1 while PSEL is 0.

Reset
REQ-026 While rst=1 the block SHALL be in state IDLE, asynchronously, including when rst asserts mid-transfer.
REQ-027 During reset PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0.
REQ-028 During reset rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0 and the timeout counter is 0.
REQ-029 In the first cycle after reset deasserts, req_ready SHALL be 1.

Configuration
REQ-030 Macro APB_MASTER_TIMEOUT_EN defined: a 16-bit counter clears on ACCESS entry and increments each ACCESS cycle with PREADY=0.
REQ-031 With APB_MASTER_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYC and PREADY=0: go to RESP, rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL/PENABLE=0 on the next cycle.
REQ-032 With APB_MASTER_TIMEOUT_EN defined, PREADY=1 in the same cycle the counter reaches TIMEOUT_CYC completes normally, because PREADY has priority.
REQ-033 Macro APB_MASTER_TIMEOUT_EN undefined: no counter exists, ACCESS waits indefinitely, and rsp_timeout is tied to 0.

Verification
REQ-034 Write 0x1000_0004 data 0xDEADBEEF strb 0xF with PREADY=1 -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-035 Read 0x1000_0008 with 3 PREADY-low cycles and PRDATA=0x12345678 -> PSTRB=0, APB outputs stable throughout, rsp_valid at N+6, rsp_rdata=0x12345678.
REQ-036 Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0; the next request is accepted one cycle after rsp_valid.
REQ-037 Request to 0x1000_0002 -> PSEL stays 0, rsp_valid at N+1 with rsp_err=1.
REQ-038 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=4, PREADY held 0 -> rsp_valid with rsp_err=1 and rsp_timeout=1; PSEL drops the same cycle.
REQ-039 Assert rst during ACCESS -> PSEL/PENABLE are 0 the same cycle with no clock edge, no rsp_valid is issued, and req_ready=1 after release.
